// File: rtl/paddle_gen.sv
// Parametrised brick-breaker paddle: tick-paced movement, edge clamping, centred width select.
// Define PADDLE_ACCEL_EN to enable hold-to-accelerate; otherwise speed is fixed at 1.
module paddle_gen #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          PAD_W       = 100,
    parameter int          PAD_H       = 20,
    parameter int          PAD_Y       = 440,
    parameter int          TICK_DIV    = 208333,
    parameter int          MAX_SPEED   = 4,
    parameter int          ACCEL_TICKS = 16,
    parameter logic [23:0] COLOR       = 24'h696969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  KEY,
    input  logic [1:0]  width_sel,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        active_pixels,
    output logic [23:0] vga_color,
    output logic [9:0]  paddle_x,
    output logic [9:0]  paddle_y,
    output logic [9:0]  paddle_width,
    output logic [9:0]  paddle_height,
    output logic [2:0]  paddle_speed
);

    typedef enum logic [1:0] {DIR_IDLE, DIR_LEFT, DIR_RIGHT} dir_e;

    localparam logic [11:0] SW12   = 12'(SCREEN_W);
    localparam logic [9:0]  W_FULL = 10'(PAD_W);
    localparam logic [9:0]  W_HALF = 10'(PAD_W / 2);
    localparam logic [9:0]  W_QTR  = 10'(PAD_W / 4);
    localparam logic [9:0]  X_RST  = 10'((SCREEN_W - PAD_W) / 2);
    localparam logic [11:0] Y_TOP  = 12'(PAD_Y);
    localparam logic [11:0] Y_END  = 12'(PAD_Y + PAD_H);
    localparam logic [11:0] Y_LIM  = 12'(SCREEN_H);

    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic        tick_q, tick_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  w_q, w_d;
    logic [2:0]  speed_q;
    dir_e        dir;
    logic [9:0]  w_new;

    always_comb begin
        tick_d     = (tick_cnt_q == 20'(TICK_DIV));
        tick_cnt_d = tick_d ? 20'd0 : tick_cnt_q + 20'd1;
    end

    always_comb begin
        dir = DIR_IDLE;
        if (!KEY[1] && KEY[0])
            dir = DIR_LEFT;
        else if (!KEY[0] && KEY[1])
            dir = DIR_RIGHT;
        case (width_sel)
            2'd1:    w_new = W_HALF;
            2'd2:    w_new = W_QTR;
            default: w_new = W_FULL;
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    logic [2:0]  speed_d;
    logic [15:0] hold_q, hold_d;
    dir_e        last_dir_q, last_dir_d;

    // hold_cnt counts held ticks including the one that started the press,
    // so every ACCEL_TICKS consecutive held ticks raise the speed by one.
    always_comb begin
        speed_d    = speed_q;
        hold_d     = hold_q;
        last_dir_d = last_dir_q;
        if (tick_q) begin
            last_dir_d = dir;
            if (dir == DIR_IDLE) begin
                speed_d = 3'd1;
                hold_d  = 16'd0;
            end else if (dir != last_dir_q) begin
                speed_d = 3'd1;
                hold_d  = 16'd1;
            end else if (hold_q >= 16'(ACCEL_TICKS - 1)) begin
                hold_d = 16'd0;
                if (speed_q < 3'(MAX_SPEED))
                    speed_d = speed_q + 3'd1;
            end else begin
                hold_d = hold_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_q    <= 3'd1;
            hold_q     <= 16'd0;
            last_dir_q <= DIR_IDLE;
        end else begin
            speed_q    <= speed_d;
            hold_q     <= hold_d;
            last_dir_q <= last_dir_d;
        end
    end
`else
    assign speed_q = 3'd1;
`endif

    logic [11:0]        x_ext, w_ext, spd_ext, wn_ext, x_left, x_right, x_wc;
    logic signed [11:0] diff, nx, max_x;

    always_comb begin
        x_ext   = {2'b00, x_q};
        w_ext   = {2'b00, w_q};
        wn_ext  = {2'b00, w_new};
        spd_ext = {9'd0, speed_q};
        x_left  = (x_ext >= spd_ext) ? x_ext - spd_ext : 12'd0;
        x_right = (x_ext + w_ext + spd_ext <= SW12) ? x_ext + spd_ext : SW12 - w_ext;
        // Re-centre on width change: shift by half the width difference, then clamp.
        diff  = $signed(w_ext) - $signed(wn_ext);
        nx    = $signed(x_ext) + diff / 12'sd2;
        max_x = $signed(SW12 - wn_ext);
        if (nx < 12'sd0)
            x_wc = 12'd0;
        else if (nx > max_x)
            x_wc = max_x;
        else
            x_wc = nx;

        x_d = x_q;
        w_d = w_q;
        if (tick_q) begin
            if (w_new != w_q) begin
                w_d = w_new;
                x_d = 10'(x_wc);
            end else if (dir == DIR_LEFT) begin
                x_d = 10'(x_left);
            end else if (dir == DIR_RIGHT) begin
                x_d = 10'(x_right);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= 20'd0;
            tick_q     <= 1'b0;
            x_q        <= X_RST;
            w_q        <= W_FULL;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            x_q        <= x_d;
            w_q        <= w_d;
        end
    end

    logic [11:0] px_ext, py_ext;
    logic        in_paddle;

    always_comb begin
        px_ext    = {2'b00, x};
        py_ext    = {2'b00, y};
        in_paddle = (px_ext >= x_ext) && (px_ext < x_ext + w_ext) &&
                    (py_ext >= Y_TOP) && (py_ext < Y_END) && (py_ext < Y_LIM);
        vga_color = (active_pixels && in_paddle) ? COLOR : 24'h000000;
    end

    assign paddle_x      = x_q;
    assign paddle_y      = 10'(PAD_Y);
    assign paddle_width  = w_q;
    assign paddle_height = 10'(PAD_H);
    assign paddle_speed  = speed_q;

endmodule

// File: tb/tb_paddle_gen.sv
// Self-checking bench for paddle_gen: random tick-level stimulus against a reference model,
// with expectations queued by the driver and popped by a monitor after every update edge.
module tb_paddle_gen;
    localparam int TD   = 3;
    localparam int P    = TD + 1;
    localparam int ACC  = 4;
    localparam int MAXS = 4;
    localparam int SW   = 640;
    localparam int PW   = 100;
    localparam int PH   = 20;
    localparam int PY   = 440;
    localparam logic [23:0] COL = 24'h696969;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  KEY;
    logic [1:0]  width_sel;
    logic [9:0]  px, py;
    logic        act;
    logic [23:0] vga_color;
    logic [9:0]  paddle_x, paddle_y, paddle_width, paddle_height;
    logic [2:0]  paddle_speed;

    always #5 clk = ~clk;

    paddle_gen #(
        .TICK_DIV(TD), .ACCEL_TICKS(ACC), .MAX_SPEED(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .KEY(KEY), .width_sel(width_sel),
        .x(px), .y(py), .active_pixels(act),
        .vga_color(vga_color), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .paddle_width(paddle_width), .paddle_height(paddle_height),
        .paddle_speed(paddle_speed)
    );

    // Clock edges since reset release; the paddle updates on edges P+1, 2P+1, ...
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [22:0] exp_q[$];

    int m_x, m_w, m_speed, m_held, m_dir;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int ref_color(int cx, int cy, bit a, int ox, int w);
        if (a && cx >= ox && cx < ox + w && cy >= PY && cy < PY + PH)
            return int'(COL);
        return 0;
    endfunction

    task automatic model_reset();
        m_x = (SW - PW) / 2;
        m_w = PW;
        m_speed = 1;
        m_held = 0;
        m_dir = 0;
    endtask

    // Reference: speed = 1 + (consecutive held ticks)/ACC, capped; moves use the pre-tick speed.
    task automatic model_tick(input logic [1:0] key_v, input logic [1:0] ws);
        int dir, old_spd, nw, nx;
        dir = (key_v == 2'b01) ? 1 : (key_v == 2'b10) ? 2 : 0;
        old_spd = m_speed;
        case (ws)
            2'd1:    nw = PW / 2;
            2'd2:    nw = PW / 4;
            default: nw = PW;
        endcase
        if (dir == 0)           m_held = 0;
        else if (dir != m_dir)  m_held = 1;
        else                    m_held++;
        m_dir = dir;
`ifdef PADDLE_ACCEL_EN
        m_speed = (dir == 0) ? 1 : 1 + m_held / ACC;
        if (m_speed > MAXS) m_speed = MAXS;
`else
        m_speed = 1;
`endif
        if (nw != m_w) begin
            nx = m_x + (m_w - nw) / 2;
            if (nx < 0) nx = 0;
            if (nx > SW - nw) nx = SW - nw;
            m_x = nx;
            m_w = nw;
        end else if (dir == 1) begin
            m_x = (m_x >= old_spd) ? m_x - old_spd : 0;
        end else if (dir == 2) begin
            m_x = (m_x + m_w + old_spd <= SW) ? m_x + old_spd : SW - m_w;
        end
    endtask

    task automatic wait_update();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * P && !hit; i++) begin
            @(negedge clk);
            hit = (cyc >= P + 1) && ((cyc - 1) % P == 0);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: no update edge within %0d cycles", 4 * P);
        end
    endtask

    // Called just after an update edge (or right at reset release): inputs apply to the next tick.
    task automatic step(input logic [1:0] key_v, input logic [1:0] ws);
        KEY = key_v;
        width_sel = ws;
        model_tick(key_v, ws);
        exp_q.push_back({10'(m_x), 10'(m_w), 3'(m_speed)});
        wait_update();
    endtask

    // Monitor: after each update edge compare geometry and probe the colour output.
    initial begin
        logic [22:0] e;
        int ex, ew, lo, hi, cx, cy;
        bit a;
        forever begin
            @(negedge clk);
            if (rst && cyc >= P + 1 && (cyc - 1) % P == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ex = int'(e[22:13]);
                ew = int'(e[12:3]);
                check("paddle_x", paddle_x, ex);
                check("paddle_width", paddle_width, ew);
                check("paddle_speed", paddle_speed, int'(e[2:0]));
                check("paddle_y", paddle_y, PY);
                check("paddle_height", paddle_height, PH);
                lo = (ex >= 3) ? ex - 3 : 0;
                hi = (ex + ew + 3 < 1023) ? ex + ew + 3 : 1023;
                cx = $urandom_range(hi, lo);
                cy = $urandom_range(464, 436);
                a  = ($urandom_range(3, 0) != 0);
                px = 10'(cx);
                py = 10'(cy);
                act = a;
                #1;
                check("vga_color", vga_color, ref_color(cx, cy, a, ex, ew));
            end
        end
    end

    initial begin
        int len;
        logic [1:0] k, cur_ws;
        KEY = 2'b11;
        width_sel = 2'd0;
        px = 10'd0;
        py = 10'd0;
        act = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_x", paddle_x, 270);
        check("rst_width", paddle_width, 100);
        check("rst_height", paddle_height, 20);
        check("rst_y", paddle_y, 440);
        check("rst_speed", paddle_speed, 1);
        px = 10'd300; py = 10'd450; act = 1'b1; #1;
        check("color_inside", vga_color, ref_color(300, 450, 1, m_x, m_w));
        px = 10'd269; #1;
        check("color_left_of", vga_color, ref_color(269, 450, 1, m_x, m_w));
        px = 10'd300; py = 10'd460; #1;
        check("color_below", vga_color, ref_color(300, 460, 1, m_x, m_w));
        py = 10'd450; act = 1'b0; #1;
        check("color_inactive", vga_color, ref_color(300, 450, 0, m_x, m_w));

        @(negedge clk);
        rst = 1'b1;

        repeat (12) step(2'b01, 2'd0);
        repeat (80) step(2'b01, 2'd0);
        repeat (160) step(2'b10, 2'd0);
        repeat (10) step(2'b01, 2'd0);
        repeat (2) step(2'b00, 2'd0);
        repeat (9) step(2'b10, 2'd0);
        repeat (2) step(2'b01, 2'd0);

        repeat (6) step(2'b10, 2'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_x", paddle_x, m_x);
        check("async_rst_width", paddle_width, m_w);
        check("async_rst_speed", paddle_speed, m_speed);
        @(negedge clk);
        rst = 1'b1;

        step(2'b11, 2'd1);
        repeat (300) step(2'b01, 2'd1);
        step(2'b11, 2'd0);
        step(2'b11, 2'd2);
        step(2'b11, 2'd0);
        repeat (20) step(2'b10, 2'd0);

        cur_ws = 2'd0;
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(10, 1);
            k = 2'($urandom_range(3, 0));
            if ($urandom_range(5, 0) == 0)
                cur_ws = 2'($urandom_range(3, 0));
            repeat (len) step(k, cur_ws);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
